// File: rtl/restoring_divider.sv
// restoring_divider: sequential unsigned restoring divider, one quotient bit per clock.
// Optional macro DIVIDER_DIV_ZERO_FLAG_EN adds a registered div_zero output.
module restoring_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] M,
    input  logic             parser_done,
    output logic [WIDTH-1:0] Q_product,
    output logic [WIDTH:0]   R_product,
    output logic             busy,
    output logic             done,
`ifdef DIVIDER_DIV_ZERO_FLAG_EN
    output logic             div_zero,
`endif
    output logic [1:0]       state_dbg
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             parser_done_d;
    logic             start;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   trial;
    logic             last_iter;

    // Handshake: parser_done is a level; only its rising edge starts an
    // operation, and only while IDLE. There is no backpressure: done is a
    // single-cycle pulse marking the cycle Q_product/R_product change.
    assign start     = parser_done & ~parser_done_d;
    assign a_shift   = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign trial     = a_shift - {1'b0, m_reg};
    assign last_iter = (count == CW'(WIDTH - 1));
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            parser_done_d <= 1'b0;
            a_reg         <= '0;
            q_reg         <= '0;
            m_reg         <= '0;
            count         <= '0;
            Q_product     <= '0;
            R_product     <= '0;
            done          <= 1'b0;
`ifdef DIVIDER_DIV_ZERO_FLAG_EN
            div_zero      <= 1'b0;
`endif
        end else begin
            parser_done_d <= parser_done;
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= '0;
                        q_reg <= Q;
                        m_reg <= M;
                        count <= '0;
                    end
                end
                CALC: begin
                    // A negative trial difference restores A and shifts in a 0 bit.
                    a_reg <= trial[WIDTH] ? a_shift : trial;
                    q_reg <= {q_reg[WIDTH-2:0], ~trial[WIDTH]};
                    count <= count + CW'(1);
                end
                FIN: begin
                    Q_product <= q_reg;
                    R_product <= a_reg;
                    done      <= 1'b1;
`ifdef DIVIDER_DIV_ZERO_FLAG_EN
                    div_zero  <= (m_reg == '0);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: scoreboard bench for restoring_divider (quotient, remainder,
// latency, start edge detection, busy rejection, reset abort, back-to-back, random).
module tb_restoring_divider;

    localparam int WIDTH   = 16;
    localparam int LATENCY = WIDTH + 1;

    logic             clk;
    logic             n_rst;
    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] m_in;
    logic             parser_done;
    logic [WIDTH-1:0] q_product;
    logic [WIDTH:0]   r_product;
    logic             busy;
    logic             done;
    logic [1:0]       state_dbg;
`ifdef DIVIDER_DIV_ZERO_FLAG_EN
    logic             div_zero;
`endif

    restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .Q           (q_in),
        .M           (m_in),
        .parser_done (parser_done),
        .Q_product   (q_product),
        .R_product   (r_product),
        .busy        (busy),
        .done        (done),
`ifdef DIVIDER_DIV_ZERO_FLAG_EN
        .div_zero    (div_zero),
`endif
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_done_cyc = 0;

    // scoreboard entries are {remainder, quotient}
    logic [2*WIDTH:0] exp_q[$];
    logic [2*WIDTH:0] exp_item;

    function automatic logic [2*WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] qq;
        logic [WIDTH:0]   rr;
        if (b == '0) begin
            qq = '1;
            rr = {1'b0, a};
        end else begin
            qq = a / b;
            rr = {1'b0, a % b};
        end
        return {rr, qq};
    endfunction

    always @(posedge clk) begin
        cyc++;
        #1;
        if (done === 1'b1) begin
            done_count++;
            last_done_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got Q=%0d R=%0d, required no done", q_product, r_product);
            end else begin
                exp_item = exp_q.pop_front();
                if ({r_product, q_product} !== exp_item) begin
                    errors++;
                    $display("FAIL result: got Q=%0d R=%0d, required Q=%0d R=%0d",
                             q_product, r_product, exp_item[WIDTH-1:0], exp_item[2*WIDTH:WIDTH]);
                end
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_at_done: got %b, required 0", busy);
            end
        end
    end

    // driver tasks
    task automatic pulse_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        q_in = a;
        m_in = b;
        parser_done = 1'b1;
        start_cyc = cyc + 1;
        exp_q.push_back(model(a, b));
        @(negedge clk);
        parser_done = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start_cnt;
        int i;
        start_cnt = done_count;
        i = 0;
        while (done_count == start_cnt && i < budget) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (done_count == start_cnt) begin
            errors++;
            $display("FAIL done_timeout: got no done in %0d cycles, required one", budget);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b1;
        parser_done = 1'b0;
        q_in = '0;
        m_in = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (q_product !== '0) begin errors++; $display("FAIL reset_q: got %0d, required 0", q_product); end
        checks++;
        if (r_product !== '0) begin errors++; $display("FAIL reset_r: got %0d, required 0", r_product); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
        checks++;
        if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", state_dbg); end
        n_rst = 1'b0;
    endtask

    task automatic test_basic();
        int dc;
        dc = done_count;
        @(negedge clk);
        q_in = 16'd7;
        m_in = 16'd3;
        parser_done = 1'b1;
        start_cyc = cyc + 1;
        exp_q.push_back(model(16'd7, 16'd3));
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b, required 1", busy); end
        repeat (17) @(negedge clk);
        parser_done = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (done_count !== dc + 1) begin
            errors++;
            $display("FAIL basic_done_count: got %0d, required %0d", done_count - dc, 1);
        end
        checks++;
        if (last_done_cyc - start_cyc !== LATENCY) begin
            errors++;
            $display("FAIL basic_latency: got %0d, required %0d", last_done_cyc - start_cyc, LATENCY);
        end
    endtask

    task automatic test_extremes();
        pulse_start(16'hFFFF, 16'd1);
        wait_done(40);
        pulse_start(16'd5, 16'd7);
        wait_done(40);
        pulse_start(16'd1000, 16'd10);
        wait_done(40);
        repeat (5) @(negedge clk);
        checks++;
        if (q_product !== 16'd100 || r_product !== 17'd0) begin
            errors++;
            $display("FAIL hold_outputs: got Q=%0d R=%0d, required Q=100 R=0", q_product, r_product);
        end
    endtask

    task automatic test_div_zero();
        pulse_start(16'd100, 16'd0);
        wait_done(40);
        checks++;
        if (last_done_cyc - start_cyc !== LATENCY) begin
            errors++;
            $display("FAIL div_zero_latency: got %0d, required %0d", last_done_cyc - start_cyc, LATENCY);
        end
`ifdef DIVIDER_DIV_ZERO_FLAG_EN
        checks++;
        if (div_zero !== 1'b1) begin errors++; $display("FAIL div_zero_set: got %b, required 1", div_zero); end
`endif
        pulse_start(16'd9, 16'd4);
        wait_done(40);
`ifdef DIVIDER_DIV_ZERO_FLAG_EN
        checks++;
        if (div_zero !== 1'b0) begin errors++; $display("FAIL div_zero_clear: got %b, required 0", div_zero); end
`endif
    endtask

    task automatic test_busy_reject();
        int dc;
        dc = done_count;
        pulse_start(16'd200, 16'd7);
        repeat (4) @(negedge clk);
        parser_done = 1'b1;
        q_in = 16'($urandom_range(0, 65535));
        m_in = 16'($urandom_range(0, 65535));
        @(negedge clk);
        parser_done = 1'b0;
        @(negedge clk);
        parser_done = 1'b1;
        q_in = 16'd3;
        m_in = 16'd1;
        @(negedge clk);
        checks++;
        if (q_product !== 16'd2 || r_product !== 17'd1) begin
            errors++;
            $display("FAIL hold_during_calc: got Q=%0d R=%0d, required Q=2 R=1", q_product, r_product);
        end
        parser_done = 1'b0;
        wait_done(40);
        checks++;
        if (last_done_cyc - start_cyc !== LATENCY) begin
            errors++;
            $display("FAIL busy_latency: got %0d, required %0d", last_done_cyc - start_cyc, LATENCY);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (done_count !== dc + 1) begin
            errors++;
            $display("FAIL busy_done_count: got %0d, required 1", done_count - dc);
        end
    endtask

    task automatic test_reset_mid();
        int dc;
        pulse_start(16'd7, 16'd3);
        repeat (4) @(negedge clk);
        dc = done_count;
        n_rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        checks++;
        if (q_product !== '0 || r_product !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got Q=%0d R=%0d, required 0 0", q_product, r_product);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flags: got busy=%b done=%b, required 0 0", busy, done);
        end
        // parser_done already high when reset releases counts as a start
        q_in = 16'd7;
        m_in = 16'd3;
        parser_done = 1'b1;
        @(negedge clk);
        n_rst = 1'b0;
        start_cyc = cyc + 1;
        exp_q.push_back(model(16'd7, 16'd3));
        wait_done(40);
        parser_done = 1'b0;
        checks++;
        if (last_done_cyc - start_cyc !== LATENCY) begin
            errors++;
            $display("FAIL midreset_latency: got %0d, required %0d", last_done_cyc - start_cyc, LATENCY);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_count !== dc + 1) begin
            errors++;
            $display("FAIL midreset_done_count: got %0d, required 1", done_count - dc);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        q_in = 16'd50;
        m_in = 16'd6;
        parser_done = 1'b1;
        start_cyc = cyc + 1;
        exp_q.push_back(model(16'd50, 16'd6));
        repeat (17) @(negedge clk);
        checks++;
        if (state_dbg !== 2'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_fin: got state=%0d busy=%b, required 2 1", state_dbg, busy);
        end
        parser_done = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b, required 1", done); end
        q_in = 16'd77;
        m_in = 16'd5;
        parser_done = 1'b1;
        start_cyc = cyc + 1;
        exp_q.push_back(model(16'd77, 16'd5));
        wait_done(40);
        parser_done = 1'b0;
        checks++;
        if (last_done_cyc - start_cyc !== LATENCY) begin
            errors++;
            $display("FAIL b2b_latency: got %0d, required %0d", last_done_cyc - start_cyc, LATENCY);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom_range(0, 65535));
            if (i % 4 == 0) b = 16'($urandom_range(1, 15));
            else            b = 16'($urandom_range(1, 65535));
            pulse_start(a, b);
            wait_done(40);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_busy_reject();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential unsigned restoring divider for the UART calculator datapath.
- Starts when the upstream parser raises parser_done. Divides a 16-bit dividend by a 16-bit divisor, one quotient bit per clock.
- Holds quotient and remainder on its outputs until the next operation completes.

Parameters:
- WIDTH, 16, operand width. Quotient is WIDTH bits; remainder is WIDTH+1 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  synchronous, active-high reset. The name is kept for codebase consistency; a value of 1 resets.
- Q  input  WIDTH  dividend, unsigned.
- M  input  WIDTH  divisor, unsigned.
- parser_done  input  1  start request; a level that is edge-detected internally.
- Q_product  output  WIDTH  quotient, registered.
- R_product  output  WIDTH+1  remainder, registered. The MSB is always 0 for a completed result.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when Q_product/R_product are updated.

Behaviour:
- Reset (n_rst=1 at a rising edge):
  - Q_product=0, R_product=0, busy=0, done=0.
  - State=IDLE, bit counter=0, parser_done delay register=0.
  - Reset overrides any operation in progress; the partial result is discarded.
- Start detect:
  - start = parser_done & ~parser_done_d, where parser_done_d is registered every cycle.
  - A level held high triggers exactly once.
  - Because the delay register resets to 0, parser_done already high at the first cycle after reset counts as a start.
  - A start while busy is ignored; the in-flight operation is not affected.
- States: IDLE, CALC, FIN.
- IDLE:
  - On start: latch A=0 (WIDTH+1 bits), Qr=Q, Mr=M, count=0; go to CALC; busy=1.
  - Operands are sampled only on this edge; later changes to Q/M do not matter.
- CALC, one iteration per cycle, WIDTH iterations:
  - Shift {A,Qr} left by 1.
  - Compute T = A - {1'b0,Mr}, in WIDTH+1 bits.
  - If T[WIDTH]=1 (negative): keep A and set Qr[0]=0. Otherwise A=T and Qr[0]=1.
  - count++. After iteration WIDTH-1 completes, go to FIN.
- FIN (one cycle):
  - Q_product=Qr, R_product=A; done=1 for this one cycle.
  - busy=0; return to IDLE.
  - A start may be accepted on the first IDLE cycle after FIN.
- Latency: the start edge is cycle 0; results are visible and done=1 after edge WIDTH+1 (17 for WIDTH=16).
- Outputs are unchanged between completions, including during a new calculation.
- Divide by zero (Mr=0), handled with no special case:
  - Every trial subtraction succeeds, so Q_product = all ones (0xFFFF) and R_product = dividend zero-extended.
  - Latency is the same as a normal operation.
- Results satisfy Q_product*M + R_product = Q and R_product < M for M≠0.

Optional Feature:
- Macro: DIVIDER_DIV_ZERO_FLAG_EN.
- Defined:
  - Extra output port div_zero (1 bit, reset 0).
  - It is registered in FIN: set to 1 when the latched divisor Mr==0, cleared to 0 for a nonzero divisor.
  - It holds its value until the next FIN or reset.
  - Quotient/remainder behaviour is unchanged.
- Not defined: the port and its logic are absent.

Test Plan:
- Reset then start: n_rst high for 1+ cycles, then Q=7, M=3, parser_done 0→1 held high 20 cycles → after 17 edges Q_product=2, R_product=1, done pulses exactly once, with no retrigger while held high.
- Exact and extremes: Q=0xFFFF, M=1 → Q_product=0xFFFF, R_product=0; Q=5, M=7 → Q_product=0, R_product=5; Q=1000, M=10 → Q_product=100, R_product=0.
- Divide by zero: Q=100, M=0 → Q_product=0xFFFF, R_product=100; with DIVIDER_DIV_ZERO_FLAG_EN, div_zero=1, then 0 after a following 9/4 operation (result 2 r 1).
- Busy rejection and operand stability: start 200/7, then toggle parser_done and change Q/M mid-CALC → result 28 r 4 at the original latency, and no second done.
- Reset mid-operation: start 7/3, assert n_rst at cycle 5 → outputs 0, busy=0, no done; a new start after reset produces 2 r 1.
- Back-to-back and random: drop parser_done in FIN, re-raise on the first IDLE cycle → second result correct. Run 1000 random Q/M pairs with M≠0 against Q/M and Q%M.
